quantum_preempt_ctrl: RTL and testbench

Clocked, parametrised successor to the combinational PC/OS-switch controller. It owns the instruction-quantum counter, which is programmable rather than fixed at 10, and decides when user execution is preempted or ends. On a trap it saves the interrupted PC and redirects fetch to the OS context-switch entry. It holds OS mode until the OS signals completion, then redirects fetch to the OS-selected resume PC. It sits between the PC register and the fetch mux.

---
 rtl/quantum_preempt_ctrl.sv | 157 +++++++++++++++
 tb/tb_quantum_preempt_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/quantum_preempt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : quantum_preempt_ctrl
// Description : Instruction-quantum preemption controller. Counts retired
//               user instructions, traps to the OS context-switch entry when
//               the programmable quantum expires or the process exits, holds
//               OS mode until the OS reports completion, then redirects fetch
//               to the OS-selected resume PC. Sits between the PC register
//               and the fetch mux.
// Ports       : clock, reset       - clock, synchronous active-high reset
//               instr_valid        - one user instruction retires this cycle
//               end_proc           - process executed its exit instruction
//               preempt_en         - enable quantum-based preemption
//               quantum_we/in      - quantum register write strobe / value
//               so_done, resume_pc - OS finished; PC to resume user mode at
//               pc_curr            - current PC from the PC register
//               pc_new             - next PC for the fetch mux (combinational)
//               pc_override        - PC register must load pc_new
//               enable_so          - high while in TRAP or KERNEL
//               saved_pc           - PC captured at the last trap
//               trap_cause         - bit0 quantum expired, bit1 end_proc
//               instr_count        - instructions retired in current slice
// Revision    : 1.0 - initial release
// ============================================================================
module quantum_preempt_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int CNT_WIDTH       = 8,
    parameter int DEFAULT_QUANTUM = 10,
    parameter int SO_ENTRY        = 17
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic                  end_proc,
    input  logic                  preempt_en,
    input  logic                  quantum_we,
    input  logic [CNT_WIDTH-1:0]  quantum_in,
    input  logic                  so_done,
    input  logic [DATA_WIDTH-1:0] resume_pc,
    input  logic [DATA_WIDTH-1:0] pc_curr,
    output logic [DATA_WIDTH-1:0] pc_new,
    output logic                  pc_override,
    output logic                  enable_so,
    output logic [DATA_WIDTH-1:0] saved_pc,
    output logic [1:0]            trap_cause,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    localparam logic [1:0] c_st_user   = 2'd0;
    localparam logic [1:0] c_st_trap   = 2'd1;
    localparam logic [1:0] c_st_kernel = 2'd2;

    localparam logic [CNT_WIDTH-1:0]  c_cnt_max      = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  c_quantum_rst  = CNT_WIDTH'(DEFAULT_QUANTUM);
    localparam logic [DATA_WIDTH-1:0] c_so_entry     = DATA_WIDTH'(SO_ENTRY);
    localparam logic [CNT_WIDTH:0]    c_one_wide     = (CNT_WIDTH+1)'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_quantum;
    logic [DATA_WIDTH-1:0] r_saved_pc;
    logic [1:0]            r_trap_cause;
    logic                  r_enable_so;
    logic                  w_q_hit;
    logic                  w_trap;

    // Compare one bit wider than the counter so a saturated count plus the
    // retiring instruction cannot wrap below the quantum.
    assign w_q_hit = preempt_en & instr_valid & (r_quantum != '0) &
                     (({1'b0, r_count} + c_one_wide) >= {1'b0, r_quantum});
    assign w_trap  = w_q_hit | end_proc;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_user;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and fetch redirect
    always_comb begin
        w_next_state = r_state;
        pc_override  = 1'b0;
        pc_new       = pc_curr;
        if (!reset) begin
            case (r_state)
                c_st_user: begin
                    if (w_trap) begin
                        w_next_state = c_st_trap;
                    end
                end
                c_st_trap: begin
                    pc_override  = 1'b1;
                    pc_new       = c_so_entry;
                    w_next_state = c_st_kernel;
                end
                c_st_kernel: begin
                    if (so_done) begin
                        pc_override  = 1'b1;
                        pc_new       = resume_pc;
                        w_next_state = c_st_user;
                    end
                end
                default: begin
                    w_next_state = c_st_user;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count      <= '0;
            r_quantum    <= c_quantum_rst;
            r_saved_pc   <= '0;
            r_trap_cause <= 2'b00;
            r_enable_so  <= 1'b0;
        end else begin
            // The trap decision this cycle already used the old quantum.
            if (quantum_we) begin
                r_quantum <= quantum_in;
            end
            r_enable_so <= (w_next_state != c_st_user);
            case (r_state)
                c_st_user: begin
                    if (w_trap) begin
                        r_saved_pc   <= pc_curr;
                        r_count      <= '0;
                        r_trap_cause <= {end_proc, w_q_hit};
                    end else if (instr_valid && (r_count != c_cnt_max)) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_st_kernel: begin
                    r_count <= '0;
                    if (so_done) begin
                        r_trap_cause <= 2'b00;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign enable_so   = r_enable_so;
    assign saved_pc    = r_saved_pc;
    assign trap_cause  = r_trap_cause;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_quantum_preempt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_quantum_preempt_ctrl
// Description : Directed self-checking bench for quantum_preempt_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quantum_preempt_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        end_proc;
    logic        preempt_en;
    logic        quantum_we;
    logic [7:0]  quantum_in;
    logic        so_done;
    logic [31:0] resume_pc;
    logic [31:0] pc_curr;
    logic [31:0] pc_new;
    logic        pc_override;
    logic        enable_so;
    logic [31:0] saved_pc;
    logic [1:0]  trap_cause;
    logic [7:0]  instr_count;

    int checks = 0;
    int errors = 0;
    int trap_seen;

    quantum_preempt_ctrl #(
        .DATA_WIDTH      (32),
        .CNT_WIDTH       (8),
        .DEFAULT_QUANTUM (10),
        .SO_ENTRY        (17)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .end_proc    (end_proc),
        .preempt_en  (preempt_en),
        .quantum_we  (quantum_we),
        .quantum_in  (quantum_in),
        .so_done     (so_done),
        .resume_pc   (resume_pc),
        .pc_curr     (pc_curr),
        .pc_new      (pc_new),
        .pc_override (pc_override),
        .enable_so   (enable_so),
        .saved_pc    (saved_pc),
        .trap_cause  (trap_cause),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; end_proc = 1'b0; preempt_en = 1'b1;
        quantum_we = 1'b0; quantum_in = 8'd0; so_done = 1'b0;
        resume_pc = 32'h0; pc_curr = 32'h40;
        tick(); tick();
        chk("rst_enable_so",   {31'd0, enable_so},   32'd0);
        chk("rst_pc_override", {31'd0, pc_override}, 32'd0);
        chk("rst_pc_new",      pc_new,               32'h40);
        chk("rst_saved_pc",    saved_pc,             32'd0);
        chk("rst_trap_cause",  {30'd0, trap_cause},  32'd0);
        chk("rst_count",       {24'd0, instr_count}, 32'd0);
        reset = 1'b0;

        // Quantum expiry after 10 instructions
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_curr = 32'h40 + 32'(4 * i);
            if (i == 9) chk("q_count_before", {24'd0, instr_count}, 32'd9);
            tick();
            if (i < 9) begin
                chk("q_no_early_trap", {31'd0, enable_so}, 32'd0);
            end
        end
        instr_valid = 1'b0;
        pc_curr = 32'h68;
        #1;
        chk("q_trap_override", {31'd0, pc_override}, 32'd1);
        chk("q_trap_pc_new",   pc_new,               32'd17);
        chk("q_trap_enable",   {31'd0, enable_so},   32'd1);
        chk("q_trap_saved",    saved_pc,             32'h64);
        chk("q_trap_cause",    {30'd0, trap_cause},  32'd1);
        chk("q_count_after",   {24'd0, instr_count}, 32'd0);
        tick();
        chk("k_override_idle", {31'd0, pc_override}, 32'd0);
        chk("k_pc_new_idle",   pc_new,               32'h68);

        // Kernel ignores end_proc and instr_valid
        for (int i = 0; i < 5; i++) begin
            end_proc = i[0];
            instr_valid = ~i[0];
            tick();
            chk("k_enable_hold", {31'd0, enable_so},   32'd1);
            chk("k_count_zero",  {24'd0, instr_count}, 32'd0);
        end
        end_proc = 1'b0; instr_valid = 1'b0;
        chk("k_cause_hold", {30'd0, trap_cause}, 32'd1);
        so_done = 1'b1; resume_pc = 32'h200;
        #1;
        chk("k_done_override", {31'd0, pc_override}, 32'd1);
        chk("k_done_pc_new",   pc_new,               32'h200);
        tick();
        so_done = 1'b0;
        chk("u_enable_off",  {31'd0, enable_so},   32'd0);
        chk("u_count_zero",  {24'd0, instr_count}, 32'd0);
        chk("u_cause_clear", {30'd0, trap_cause},  32'd0);
        chk("u_saved_hold",  saved_pc,             32'h64);

        // end_proc trap with count 3
        instr_valid = 1'b1;
        tick(); tick(); tick();
        chk("e_count3", {24'd0, instr_count}, 32'd3);
        instr_valid = 1'b0; end_proc = 1'b1; pc_curr = 32'h80;
        tick();
        end_proc = 1'b0;
        chk("e_enable",   {31'd0, enable_so},  32'd1);
        chk("e_cause",    {30'd0, trap_cause}, 32'd2);
        chk("e_saved",    saved_pc,            32'h80);
        chk("e_override", {31'd0, pc_override}, 32'd1);
        tick();
        so_done = 1'b1; tick(); so_done = 1'b0;

        // Both causes at once
        instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("b_count9", {24'd0, instr_count}, 32'd9);
        end_proc = 1'b1; pc_curr = 32'h90;
        tick();
        end_proc = 1'b0; instr_valid = 1'b0;
        chk("b_cause",    {30'd0, trap_cause},  32'd3);
        chk("b_override", {31'd0, pc_override}, 32'd1);
        tick();
        chk("b_single_trap", {31'd0, pc_override}, 32'd0);
        chk("b_enable",      {31'd0, enable_so},   32'd1);
        so_done = 1'b1; tick(); so_done = 1'b0;

        // Lower quantum below current count
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        instr_valid = 1'b0; quantum_we = 1'b1; quantum_in = 8'd3;
        tick();
        quantum_we = 1'b0;
        chk("w_no_trap_on_write", {31'd0, enable_so},   32'd0);
        chk("w_count5",           {24'd0, instr_count}, 32'd5);
        instr_valid = 1'b1; pc_curr = 32'hA0;
        tick();
        instr_valid = 1'b0;
        chk("w_trap_cause", {30'd0, trap_cause}, 32'd1);
        chk("w_trap_saved", saved_pc,            32'hA0);
        tick();
        so_done = 1'b1; tick(); so_done = 1'b0;

        // Quantum 0 disables preemption; counter saturates
        quantum_we = 1'b1; quantum_in = 8'd0;
        tick();
        quantum_we = 1'b0;
        trap_seen = 0;
        instr_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (enable_so) trap_seen++;
        end
        chk("z_no_trap",  32'(trap_seen),        32'd0);
        chk("z_saturate", {24'd0, instr_count},  32'd255);

        // preempt_en=0 with quantum 10 at a saturated count
        instr_valid = 1'b0; preempt_en = 1'b0;
        quantum_we = 1'b1; quantum_in = 8'd10;
        tick();
        quantum_we = 1'b0;
        trap_seen = 0;
        instr_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (enable_so) trap_seen++;
        end
        chk("p_no_trap",  32'(trap_seen),       32'd0);
        chk("p_saturate", {24'd0, instr_count}, 32'd255);

        // Re-enable: 255+1 >= 10 must trap without wrapping
        preempt_en = 1'b1; pc_curr = 32'hC0;
        tick();
        instr_valid = 1'b0;
        chk("s_trap_enable", {31'd0, enable_so},  32'd1);
        chk("s_trap_cause",  {30'd0, trap_cause}, 32'd1);
        tick();

        // Reset while in KERNEL
        chk("r_in_kernel", {31'd0, enable_so}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_enable",   {31'd0, enable_so},   32'd0);
        chk("r_saved",    saved_pc,             32'd0);
        chk("r_cause",    {30'd0, trap_cause},  32'd0);
        chk("r_count",    {24'd0, instr_count}, 32'd0);

        // Quantum back at default: trap after 10 instructions
        instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("r_q_count9", {24'd0, instr_count}, 32'd9);
        chk("r_q_notrap", {31'd0, enable_so},   32'd0);
        tick();
        instr_valid = 1'b0;
        chk("r_q_trap", {31'd0, enable_so}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
